// File: rtl/bist_misr_checker_if.sv
// Handshake bundle between the BIST controller / CUT response path and the MISR checker.
// The master drives the run control and response stream; the slave reports status and signature.
interface bist_misr_checker_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
);
    logic             start;
    logic             abort;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic [WIDTH-1:0] golden;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CW-1:0]    count;

    modport master (
        output start, abort, resp_valid, resp_data, golden,
        input  busy, done, pass, signature, count
    );

    modport slave (
        input  start, abort, resp_valid, resp_data, golden,
        output busy, done, pass, signature, count
    );
endinterface

// File: rtl/bist_misr_checker.sv
// Output response analyzer: compacts CUT response words into a MISR over a fixed
// number of beats, then compares the final signature against a golden value.
module bist_misr_checker #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter int               NUM_PATTERNS = 255,
    parameter int               CW           = 8
) (
    input logic                clk_i,
    input logic                rst_ni,
    bist_misr_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_PATTERNS);

    state_e           state_q;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             pass_q;

    // One MISR step: shift left, fold the dropped MSB back through the tap mask, mix in the word.
    always_comb begin
        sig_d   = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ bus.resp_data;
        count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= CAPTURE;
                        sig_q   <= SEED;
                        count_q <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (bus.resp_valid) begin
                        sig_q   <= sig_d;
                        count_q <= count_d;
                        if (count_d == LAST_COUNT) begin
                            state_q <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    pass_q  <= (sig_q == bus.golden);
                    state_q <= DONE;
                end
                DONE: begin
                    // Re-arm straight from DONE so back-to-back runs skip IDLE.
                    if (bus.start) begin
                        state_q <= CAPTURE;
                        sig_q   <= SEED;
                        count_q <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q == CAPTURE) || (state_q == COMPARE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench for bist_misr_checker: table-driven runs, randomized runs against
// an arithmetic MISR model, and hand-written abort/reset/restart sequences.
module tb_bist_misr_checker;

    localparam int         W     = 4;
    localparam logic [3:0] POLYV = 4'h3;

    typedef struct {
        string      name;
        logic [15:0] beats;
        logic [7:0]  gaps;
        logic [3:0]  golden;
        logic [3:0]  expSig;
        logic        expPass;
    } vec_t;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    vec_t vecs[6];

    bist_misr_checker_if #(.WIDTH(W), .CW(3)) bif ();
    bist_misr_checker_if #(.WIDTH(W), .CW(2)) bif2 ();

    bist_misr_checker #(
        .WIDTH(W), .POLY(POLYV), .SEED(4'h0), .NUM_PATTERNS(4), .CW(3)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bif)
    );

    bist_misr_checker #(
        .WIDTH(W), .POLY(POLYV), .SEED(4'h8), .NUM_PATTERNS(1), .CW(2)
    ) dut2 (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MISR step from plain arithmetic: doubling modulo 16, taps applied when the old value overflowed.
    function automatic logic [3:0] modelStep(input logic [3:0] s, input logic [3:0] d);
        int v;
        v = (int'(s) * 2) % 16;
        if (int'(s) >= 8) v = v ^ int'(POLYV);
        v = v ^ int'(d);
        return v[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Full run: start, four beats with optional bubbles, compare cycle, DONE hold.
    task automatic applyStimulus(input string name, input logic [15:0] beats, input logic [7:0] gaps,
                                 input logic [3:0] golden, input logic [3:0] expSig, input logic expPass);
        logic [3:0] s;
        int g;
        bif.golden = golden;
        bif.start  = 1'b1;
        tick();
        bif.start = 1'b0;
        checkOutput({name, " start busy"}, 32'(bif.busy), 32'd1);
        checkOutput({name, " start done"}, 32'(bif.done), 32'd0);
        checkOutput({name, " start count"}, 32'(bif.count), 32'd0);
        checkOutput({name, " start sig"}, 32'(bif.signature), 32'd0);
        s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            g = int'(gaps[2*i +: 2]);
            for (int k = 0; k < g; k++) begin
                bif.resp_valid = 1'b0;
                bif.resp_data  = 4'h5;
                tick();
                checkOutput({name, " bubble busy"}, 32'(bif.busy), 32'd1);
                checkOutput({name, " bubble count"}, 32'(bif.count), 32'(i));
                checkOutput({name, " bubble sig"}, 32'(bif.signature), 32'(s));
            end
            bif.resp_valid = 1'b1;
            bif.resp_data  = beats[4*i +: 4];
            s = modelStep(s, beats[4*i +: 4]);
            tick();
            checkOutput({name, " beat count"}, 32'(bif.count), 32'(i + 1));
            checkOutput({name, " beat sig"}, 32'(bif.signature), 32'(s));
            checkOutput({name, " beat busy"}, 32'(bif.busy), 32'd1);
        end
        // Extra beat during COMPARE must be ignored.
        bif.resp_valid = 1'b1;
        bif.resp_data  = 4'h7;
        checkOutput({name, " compare done"}, 32'(bif.done), 32'd0);
        tick();
        bif.resp_valid = 1'b0;
        checkOutput({name, " done"}, 32'(bif.done), 32'd1);
        checkOutput({name, " done busy"}, 32'(bif.busy), 32'd0);
        checkOutput({name, " final sig"}, 32'(bif.signature), 32'(expSig));
        checkOutput({name, " pass"}, 32'(bif.pass), 32'(expPass));
        checkOutput({name, " final count"}, 32'(bif.count), 32'd4);
        tick();
        checkOutput({name, " hold done"}, 32'(bif.done), 32'd1);
        checkOutput({name, " hold pass"}, 32'(bif.pass), 32'(expPass));
        checkOutput({name, " hold sig"}, 32'(bif.signature), 32'(expSig));
    endtask

    initial begin
        logic [15:0] rb;
        logic [7:0]  rg;
        logic [3:0]  rs;
        logic [3:0]  rgold;

        checks = 0;
        errors = 0;
        vecs[0] = '{"basic",   16'h1111, 8'h00, 4'hF, 4'hF, 1'b1};
        vecs[1] = '{"fail",    16'h1111, 8'h00, 4'hE, 4'hF, 1'b0};
        vecs[2] = '{"bubbles", 16'h1111, 8'h34, 4'hF, 4'hF, 1'b1};
        vecs[3] = '{"fbpath",  16'h0008, 8'h00, 4'hC, 4'hC, 1'b1};
        vecs[4] = '{"allF",    16'hFFFF, 8'h00, 4'hA, 4'hA, 1'b1};
        vecs[5] = '{"allFbad", 16'hFFFF, 8'h15, 4'h0, 4'hA, 1'b0};

        rstN = 1'b0;
        bif.start = 1'b0;  bif.abort = 1'b0;  bif.resp_valid = 1'b0;  bif.resp_data = '0;  bif.golden = '0;
        bif2.start = 1'b0; bif2.abort = 1'b0; bif2.resp_valid = 1'b0; bif2.resp_data = '0; bif2.golden = 4'h3;
        #12;
        checkOutput("reset sig", 32'(bif.signature), 32'd0);
        checkOutput("reset busy", 32'(bif.busy), 32'd0);
        checkOutput("reset done", 32'(bif.done), 32'd0);
        checkOutput("reset seed dut2", 32'(bif2.signature), 32'h8);
        rstN = 1'b1;
        tick();

        // IDLE ignores response beats.
        bif.resp_valid = 1'b1;
        bif.resp_data  = 4'h9;
        tick();
        bif.resp_valid = 1'b0;
        checkOutput("idle ignore sig", 32'(bif.signature), 32'd0);
        checkOutput("idle ignore count", 32'(bif.count), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].beats, vecs[i].gaps, vecs[i].golden, vecs[i].expSig, vecs[i].expPass);
        end

        for (int r = 0; r < 20; r++) begin
            rb = 16'($urandom);
            rg = 8'($urandom);
            rs = 4'h0;
            for (int i = 0; i < 4; i++) rs = modelStep(rs, rb[4*i +: 4]);
            rgold = (r % 2 == 0) ? rs : 4'($urandom);
            applyStimulus("random", rb, rg, rgold, rs, rgold == rs);
        end

        // Abort after two beats: back to IDLE with seed, no done.
        applyStimulus("prerun", 16'h1111, 8'h00, 4'hF, 4'hF, 1'b1);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.resp_valid = 1'b1;
        bif.resp_data  = 4'h1;
        tick();
        tick();
        checkOutput("preabort sig", 32'(bif.signature), 32'h3);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        bif.resp_valid = 1'b0;
        checkOutput("abort busy", 32'(bif.busy), 32'd0);
        checkOutput("abort done", 32'(bif.done), 32'd0);
        checkOutput("abort sig", 32'(bif.signature), 32'd0);
        checkOutput("abort count", 32'(bif.count), 32'd0);
        checkOutput("abort pass", 32'(bif.pass), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("post abort done", 32'(bif.done), 32'd0);
        end

        // Start is ignored while capturing.
        bif.start = 1'b1;
        tick();
        bif.resp_valid = 1'b1;
        bif.resp_data  = 4'h1;
        tick();
        checkOutput("start in capture count", 32'(bif.count), 32'd1);
        tick();
        bif.start = 1'b0;
        bif.resp_valid = 1'b0;
        checkOutput("start in capture count2", 32'(bif.count), 32'd2);
        checkOutput("start in capture sig", 32'(bif.signature), 32'h3);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;

        // start+abort from DONE: abort wins.
        applyStimulus("restart", 16'h1111, 8'h00, 4'hF, 4'hF, 1'b1);
        bif.start = 1'b1;
        bif.abort = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.abort = 1'b0;
        checkOutput("start+abort busy", 32'(bif.busy), 32'd0);
        checkOutput("start+abort done", 32'(bif.done), 32'd0);
        checkOutput("start+abort pass", 32'(bif.pass), 32'd0);

        // Asynchronous reset in the middle of capture with count=3.
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.resp_valid = 1'b1;
        bif.resp_data  = 4'h1;
        repeat (3) tick();
        bif.resp_valid = 1'b0;
        checkOutput("prereset count", 32'(bif.count), 32'd3);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrun reset sig", 32'(bif.signature), 32'd0);
        checkOutput("midrun reset count", 32'(bif.count), 32'd0);
        checkOutput("midrun reset busy", 32'(bif.busy), 32'd0);
        checkOutput("midrun reset done", 32'(bif.done), 32'd0);
        checkOutput("midrun reset pass", 32'(bif.pass), 32'd0);
        tick();
        rstN = 1'b1;
        tick();

        // Feedback path with SEED=8 and a single zero beat.
        bif2.start = 1'b1;
        tick();
        bif2.start = 1'b0;
        bif2.resp_valid = 1'b1;
        bif2.resp_data  = 4'h0;
        tick();
        bif2.resp_valid = 1'b0;
        checkOutput("fb sig", 32'(bif2.signature), 32'h3);
        checkOutput("fb busy", 32'(bif2.busy), 32'd1);
        tick();
        checkOutput("fb done", 32'(bif2.done), 32'd1);
        checkOutput("fb pass", 32'(bif2.pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
- Output response analyzer for the BIST chain: the receiving end of the pattern-generator/CUT path.
- Compacts a stream of CUT response words into a multiple-input signature register (MISR) over a fixed number of patterns.
- Compares the final signature against a golden value and reports pass/fail to the BIST controller.

Parameters:
- WIDTH, 8: response word and signature width in bits (≥ 2).
- POLY, 8'hB8: MISR feedback tap mask, WIDTH bits; bit i set means feedback XORs into bit i.
- SEED, 0: signature value loaded at the start of each run.
- NUM_PATTERNS, 255: number of valid response beats compacted per run (≥ 1).
- CW, 8: pattern counter width; must satisfy 2^CW > NUM_PATTERNS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
- abort  input  1  synchronous; cancels the run and returns to IDLE.
- resp_valid  input  1  resp_data carries a CUT response this cycle.
- resp_data  input  WIDTH  CUT response word.
- golden  input  WIDTH  expected final signature; sampled in COMPARE.
- busy  output  1  high in CAPTURE and COMPARE.
- done  output  1  high in DONE; run finished.
- pass  output  1  valid while done=1; 1 means signature == golden.
- signature  output  WIDTH  current MISR contents.
- count  output  CW  number of beats compacted so far in this run.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0.
- States: IDLE, CAPTURE, COMPARE, DONE; 2-bit registered state. busy and done decode directly from state.
- IDLE:
  - start=1 → CAPTURE; signature←SEED, count←0.
  - resp_valid is ignored.
- CAPTURE:
  - On each edge with resp_valid=1: fb = signature[WIDTH-1]; signature ← ((signature<<1) truncated to WIDTH) ^ (fb ? POLY : 0) ^ resp_data; count ← count+1.
  - resp_valid=0: signature and count hold (bubbles allowed, any length).
  - The beat that makes count reach NUM_PATTERNS moves the FSM to COMPARE on the same edge.
  - Beats arriving after that are ignored.
  - start is ignored in CAPTURE.
- COMPARE: exactly one cycle. pass ← (signature == golden); state → DONE.
- DONE:
  - done=1; pass, signature and count hold.
  - start=1 → CAPTURE with a fresh SEED/count clear and done deasserted; re-arm without passing through IDLE.
- Latency: last beat captured at edge E → busy stays 1 through cycle E+1 → done=1 and pass valid after edge E+1.
- abort=1 in any state → IDLE next edge; signature←SEED, count←0, pass←0. abort takes priority over start and resp_valid.
- start and abort asserted together → abort wins.
- Reset mid-run: immediate return to reset values; no partial result is reported.
- count never exceeds NUM_PATTERNS. signature wraps naturally through the polynomial; no saturation.

Test Plan:
- Reset check: assert rst=0 mid-CAPTURE with count=3 → outputs immediately signature=SEED, count=0, busy=0, done=0, pass=0.
- Basic pass (WIDTH=4, POLY=4'h3, SEED=0, NUM_PATTERNS=4):
  - Input: start, then resp_data=1 valid for 4 consecutive cycles, golden=4'hF.
  - Signature sequence: 1, 3, 7, F.
  - count=4; done=1 one cycle after the 4th beat edge; pass=1.
- Fail: same stimulus with golden=4'hE → signature=F, done=1, pass=0.
- Bubbles:
  - Input: same 4 beats with resp_valid=0 gaps of 1, 3 and 0 cycles between them, and resp_data=5 driven during the gaps.
  - Required: signature stays F, pass=1; busy=1 throughout, count increments only on valid beats.
- Feedback path: SEED=4'h8, NUM_PATTERNS=1, resp_data=0 → fb=1, signature=4'h3; golden=3 gives pass=1.
- Abort/restart:
  - abort after 2 beats → IDLE, signature=SEED, count=0, no done pulse.
  - From DONE, start → done drops next cycle and a fresh run reproduces F/pass=1.
  - start+abort in the same cycle → IDLE.
